// File: rtl/decode_pkg.sv
// Shared constants, state encoding and the immediate-detection helper
// used by the decode stage.
package decode_pkg;

  // Opcode field values the decoder cares about. Everything else is
  // forwarded to EXECUTE untouched.
  localparam logic [3:0] C_OP_MOV  = 4'h1;
  localparam logic [3:0] C_OP_ADD  = 4'h2;
  localparam logic [3:0] C_OP_JMP  = 4'hE;

  // Operand addressing modes.
  localparam logic [1:0] C_MODE_REG     = 2'b00;
  localparam logic [1:0] C_MODE_IND     = 2'b01;
  localparam logic [1:0] C_MODE_POSTINC = 2'b10;
  localparam logic [1:0] C_MODE_IDX     = 2'b11;

  // PC as a register number: "@PC+" means the operand is the next word.
  localparam logic [3:0] C_PC_REG = 4'd15;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_INST  = 3'd1,
    ST_SRC   = 3'd2,
    ST_DST   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Returns {has_src_imm, has_dst_imm} for an opcode word.
  function automatic logic [1:0] imm_flags(input logic [15:0] w);
    imm_flags = {(w[11:8] == C_PC_REG) && (w[7:6] == C_MODE_POSTINC),
                 (w[5:2]  == C_PC_REG) && (w[1:0] == C_MODE_POSTINC)};
  endfunction

endpackage

// File: rtl/decode_if.sv
// Signal bundle between the decode stage and its neighbours (FETCH and
// EXECUTE). Names carry the decode stage's own direction suffix.
//
// Handshakes: a FETCH word moves on a rising edge where fe_valid_i and
// fe_ready_o are both high; a decoded instruction moves on a rising edge
// where exe_valid_o and exe_ready_i are both high, and the exe_* fields are
// held stable while exe_valid_o waits for exe_ready_i. fe_valid_o and
// exe_jmp_valid_i are single-cycle pulses with no back-pressure.
interface decode_if;
  logic        fe_valid_i;
  logic        fe_ready_o;
  logic [15:0] fe_addr_i;
  logic [15:0] fe_data_i;
  logic        fe_valid_o;
  logic [15:0] fe_addr_o;
  logic        exe_valid_o;
  logic        exe_ready_i;
  logic [15:0] exe_addr_o;
  logic [3:0]  exe_opcode_o;
  logic [3:0]  exe_src_reg_o;
  logic [1:0]  exe_src_mode_o;
  logic [3:0]  exe_dst_reg_o;
  logic [1:0]  exe_dst_mode_o;
  logic [15:0] exe_src_imm_o;
  logic [15:0] exe_dst_imm_o;
  logic        exe_jmp_valid_i;
  logic [15:0] exe_jmp_addr_i;

  // Decode stage view.
  modport master (
    input  fe_valid_i, fe_addr_i, fe_data_i, exe_ready_i,
           exe_jmp_valid_i, exe_jmp_addr_i,
    output fe_ready_o, fe_valid_o, fe_addr_o, exe_valid_o, exe_addr_o,
           exe_opcode_o, exe_src_reg_o, exe_src_mode_o, exe_dst_reg_o,
           exe_dst_mode_o, exe_src_imm_o, exe_dst_imm_o
  );

  // FETCH/EXECUTE view.
  modport slave (
    output fe_valid_i, fe_addr_i, fe_data_i, exe_ready_i,
           exe_jmp_valid_i, exe_jmp_addr_i,
    input  fe_ready_o, fe_valid_o, fe_addr_o, exe_valid_o, exe_addr_o,
           exe_opcode_o, exe_src_reg_o, exe_src_mode_o, exe_dst_reg_o,
           exe_dst_mode_o, exe_src_imm_o, exe_dst_imm_o
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: assembles opcode + inline immediates from FETCH, resolves
// immediate absolute jumps locally and forwards everything else to EXECUTE.
// Also the only source of new-PC pulses back to FETCH.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic   clk_i,
  input  logic   rst_i,
  decode_if.master bus,
  output state_t dbg_state_o
);

  state_t      r_state;
  logic        r_fe_valid;
  logic [15:0] r_fe_addr;
  logic        r_exe_valid;
  logic [15:0] r_exe_addr;
  logic [3:0]  r_opcode;
  logic [3:0]  r_src_reg;
  logic [1:0]  r_src_mode;
  logic [3:0]  r_dst_reg;
  logic [1:0]  r_dst_mode;
  logic [15:0] r_src_imm;
  logic [15:0] r_dst_imm;

  logic        w_fe_ready;
  logic        w_accept;
  logic        w_capture;
  logic [1:0]  w_new_flags;
  logic [1:0]  w_cur_flags;

  // Flags of the word on the bus and of the instruction being assembled.
  assign w_new_flags = imm_flags(bus.fe_data_i);
  assign w_cur_flags = imm_flags({r_opcode, r_src_reg, r_src_mode,
                                  r_dst_reg, r_dst_mode});

  // Ready to FETCH: never during a redirect request or while a new-PC pulse
  // is out (the word on the bus then belongs to the old stream).
  always_comb begin
    w_fe_ready = 1'b0;
    if (!bus.exe_jmp_valid_i && !r_fe_valid) begin
      case (r_state)
        ST_INST, ST_SRC, ST_DST: w_fe_ready = 1'b1;
        ST_OUT:                  w_fe_ready = bus.exe_ready_i;
        default:                 w_fe_ready = 1'b0;
      endcase
    end
  end

  assign w_accept  = bus.fe_valid_i && w_fe_ready;
  // An opcode word is taken in ST_INST, or in ST_OUT as the previous
  // instruction leaves (back-to-back).
  assign w_capture = w_accept && ((r_state == ST_INST) || (r_state == ST_OUT));

  // Main FSM and output register bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_START;
      r_fe_valid  <= 1'b0;
      r_fe_addr   <= RESET_PC;
      r_exe_valid <= 1'b0;
      r_exe_addr  <= '0;
      r_opcode    <= '0;
      r_src_reg   <= '0;
      r_src_mode  <= '0;
      r_dst_reg   <= '0;
      r_dst_mode  <= '0;
      r_src_imm   <= '0;
      r_dst_imm   <= '0;
    end else begin
      r_fe_valid <= 1'b0;
      if (bus.exe_jmp_valid_i) begin
        // EXECUTE redirect overrides everything, including a local jump.
        r_fe_valid  <= 1'b1;
        r_fe_addr   <= bus.exe_jmp_addr_i;
        r_exe_valid <= 1'b0;
        r_state     <= ST_INST;
      end else if (w_capture) begin
        r_exe_addr <= bus.fe_addr_i;
        r_opcode   <= bus.fe_data_i[15:12];
        r_src_reg  <= bus.fe_data_i[11:8];
        r_src_mode <= bus.fe_data_i[7:6];
        r_dst_reg  <= bus.fe_data_i[5:2];
        r_dst_mode <= bus.fe_data_i[1:0];
        r_src_imm  <= '0;
        r_dst_imm  <= '0;
        if (w_new_flags[1]) begin
          r_exe_valid <= 1'b0;
          r_state     <= ST_SRC;
        end else if (w_new_flags[0]) begin
          r_exe_valid <= 1'b0;
          r_state     <= ST_DST;
        end else begin
          r_exe_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
      end else begin
        case (r_state)
          ST_START: begin
            r_fe_valid <= 1'b1;
            r_fe_addr  <= RESET_PC;
            r_state    <= ST_INST;
          end
          ST_SRC: begin
            if (w_accept) begin
              r_src_imm <= bus.fe_data_i;
              if (r_opcode == C_OP_JMP) begin
                // Absolute jump resolved here; its dst imm is never fetched.
                r_fe_valid <= 1'b1;
                r_fe_addr  <= bus.fe_data_i;
                r_state    <= ST_INST;
              end else if (w_cur_flags[0]) begin
                r_state <= ST_DST;
              end else begin
                r_exe_valid <= 1'b1;
                r_state     <= ST_OUT;
              end
            end
          end
          ST_DST: begin
            if (w_accept) begin
              r_dst_imm   <= bus.fe_data_i;
              r_exe_valid <= 1'b1;
              r_state     <= ST_OUT;
            end
          end
          ST_OUT: begin
            if (bus.exe_ready_i) begin
              r_exe_valid <= 1'b0;
              r_state     <= ST_INST;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign bus.fe_ready_o     = w_fe_ready;
  assign bus.fe_valid_o     = r_fe_valid;
  assign bus.fe_addr_o      = r_fe_addr;
  assign bus.exe_valid_o    = r_exe_valid;
  assign bus.exe_addr_o     = r_exe_addr;
  assign bus.exe_opcode_o   = r_opcode;
  assign bus.exe_src_reg_o  = r_src_reg;
  assign bus.exe_src_mode_o = r_src_mode;
  assign bus.exe_dst_reg_o  = r_dst_reg;
  assign bus.exe_dst_mode_o = r_dst_mode;
  assign bus.exe_src_imm_o  = r_src_imm;
  assign bus.exe_dst_imm_o  = r_dst_imm;
  assign dbg_state_o        = r_state;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_decode_stage;
  import decode_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     n_checks;
  int     n_pass;

  decode_if bus();

  decode_stage #(.RESET_PC(16'h0100)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    bus.fe_valid_i      = 1'b0;
    bus.fe_addr_i       = '0;
    bus.fe_data_i       = '0;
    bus.exe_ready_i     = 1'b0;
    bus.exe_jmp_valid_i = 1'b0;
    bus.exe_jmp_addr_i  = '0;
  endtask

  // Offers one word from a falling edge; returns on the falling edge after
  // the rising edge that accepted it.
  task automatic send_word(input logic [15:0] a, input logic [15:0] d);
    bit done;
    done = 1'b0;
    bus.fe_valid_i = 1'b1;
    bus.fe_addr_i  = a;
    bus.fe_data_i  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (bus.fe_ready_o === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    bus.fe_valid_i = 1'b0;
    n_checks++;
    if (!done) $display("FAIL send_word@%h: fe_ready_o stayed 0 for 20 cycles, required 1", a);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.fe_valid_o !== 1'b0) $display("FAIL rst_fe_valid: got %b want 0", bus.fe_valid_o); else n_pass++;
    n_checks++; if (bus.fe_addr_o !== 16'h0100) $display("FAIL rst_fe_addr: got %h want 0100", bus.fe_addr_o); else n_pass++;
    n_checks++; if (bus.exe_valid_o !== 1'b0) $display("FAIL rst_exe_valid: got %b want 0", bus.exe_valid_o); else n_pass++;
    n_checks++; if (bus.fe_ready_o !== 1'b0) $display("FAIL rst_fe_ready: got %b want 0", bus.fe_ready_o); else n_pass++;
    n_checks++; if (dbg_state !== ST_START) $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_START); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.fe_valid_o !== 1'b1 || bus.fe_addr_o !== 16'h0100) $display("FAIL start_pulse: got v=%b a=%h want v=1 a=0100", bus.fe_valid_o, bus.fe_addr_o); else n_pass++;
    n_checks++; if (bus.fe_ready_o !== 1'b0) $display("FAIL start_ready: got %b want 0", bus.fe_ready_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.fe_valid_o !== 1'b0 || bus.fe_ready_o !== 1'b1) $display("FAIL start_after: got v=%b r=%b want v=0 r=1", bus.fe_valid_o, bus.fe_ready_o); else n_pass++;
  endtask

  task automatic test_simple();
    bus.exe_ready_i = 1'b1;
    send_word(16'h0100, 16'h1234);
    n_checks++; if (bus.exe_valid_o !== 1'b1) $display("FAIL simple_valid: got %b want 1", bus.exe_valid_o); else n_pass++;
    n_checks++;
    if ({bus.exe_opcode_o, bus.exe_src_reg_o, bus.exe_src_mode_o, bus.exe_dst_reg_o, bus.exe_dst_mode_o} !== {4'd1, 4'd2, 2'd0, 4'd13, 2'd0})
      $display("FAIL simple_fields: got op=%h sr=%0d sm=%0d dr=%0d dm=%0d want op=1 sr=2 sm=0 dr=13 dm=0", bus.exe_opcode_o, bus.exe_src_reg_o, bus.exe_src_mode_o, bus.exe_dst_reg_o, bus.exe_dst_mode_o);
    else n_pass++;
    n_checks++; if (bus.exe_src_imm_o !== 16'h0 || bus.exe_dst_imm_o !== 16'h0) $display("FAIL simple_imms: got %h/%h want 0000/0000", bus.exe_src_imm_o, bus.exe_dst_imm_o); else n_pass++;
    n_checks++; if (bus.exe_addr_o !== 16'h0100) $display("FAIL simple_addr: got %h want 0100", bus.exe_addr_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.exe_valid_o !== 1'b0 || dbg_state !== ST_INST) $display("FAIL simple_done: got v=%b st=%0d want v=0 st=%0d", bus.exe_valid_o, dbg_state, ST_INST); else n_pass++;
  endtask

  task automatic test_src_imm_stall();
    bus.exe_ready_i = 1'b0;
    send_word(16'h0200, 16'h2F80);
    n_checks++; if (dbg_state !== ST_SRC || bus.exe_valid_o !== 1'b0) $display("FAIL srcimm_wait: got st=%0d v=%b want st=%0d v=0", dbg_state, bus.exe_valid_o, ST_SRC); else n_pass++;
    send_word(16'h0201, 16'hBEEF);
    bus.fe_valid_i = 1'b1;
    bus.fe_data_i  = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.exe_valid_o !== 1'b1 || bus.exe_src_imm_o !== 16'hBEEF || bus.exe_addr_o !== 16'h0200 ||
          bus.exe_opcode_o !== 4'h2 || bus.exe_dst_imm_o !== 16'h0 || bus.fe_ready_o !== 1'b0)
        $display("FAIL srcimm_stall%0d: got v=%b simm=%h a=%h op=%h dimm=%h rdy=%b want 1/BEEF/0200/2/0000/0",
                 i, bus.exe_valid_o, bus.exe_src_imm_o, bus.exe_addr_o, bus.exe_opcode_o, bus.exe_dst_imm_o, bus.fe_ready_o);
      else n_pass++;
      @(negedge clk);
    end
    bus.fe_valid_i  = 1'b0;
    bus.exe_ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.exe_valid_o !== 1'b0) $display("FAIL srcimm_release: got %b want 0", bus.exe_valid_o); else n_pass++;
  endtask

  task automatic test_local_jump();
    bus.exe_ready_i = 1'b1;
    // Both operands are @PC+; the dst immediate must not be fetched.
    send_word(16'h0300, 16'hEFBE);
    bus.fe_valid_i = 1'b1;
    bus.fe_addr_i  = 16'h0301;
    bus.fe_data_i  = 16'h4000;
    @(negedge clk);
    n_checks++; if (bus.fe_valid_o !== 1'b1 || bus.fe_addr_o !== 16'h4000) $display("FAIL ljmp_pulse: got v=%b a=%h want v=1 a=4000", bus.fe_valid_o, bus.fe_addr_o); else n_pass++;
    n_checks++; if (bus.fe_ready_o !== 1'b0) $display("FAIL ljmp_ready: got %b want 0", bus.fe_ready_o); else n_pass++;
    n_checks++; if (dbg_state !== ST_INST || bus.exe_valid_o !== 1'b0) $display("FAIL ljmp_state: got st=%0d v=%b want st=%0d v=0", dbg_state, bus.exe_valid_o, ST_INST); else n_pass++;
    bus.fe_valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.fe_valid_o !== 1'b0 || bus.exe_valid_o !== 1'b0) $display("FAIL ljmp_after: got fv=%b ev=%b want 0/0", bus.fe_valid_o, bus.exe_valid_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus.exe_ready_i = 1'b1;
    bus.fe_valid_i  = 1'b1;
    bus.fe_addr_i   = 16'h0400;
    bus.fe_data_i   = 16'h1234;
    @(negedge clk);
    bus.fe_addr_i = 16'h0402;
    bus.fe_data_i = 16'h5678;
    #1;
    n_checks++; if (bus.exe_valid_o !== 1'b1 || bus.exe_addr_o !== 16'h0400 || bus.exe_opcode_o !== 4'h1 || bus.fe_ready_o !== 1'b1)
      $display("FAIL b2b_first: got v=%b a=%h op=%h rdy=%b want 1/0400/1/1", bus.exe_valid_o, bus.exe_addr_o, bus.exe_opcode_o, bus.fe_ready_o);
    else n_pass++;
    @(negedge clk);
    bus.fe_valid_i = 1'b0;
    n_checks++;
    if (bus.exe_valid_o !== 1'b1 || bus.exe_addr_o !== 16'h0402 ||
        {bus.exe_opcode_o, bus.exe_src_reg_o, bus.exe_src_mode_o, bus.exe_dst_reg_o, bus.exe_dst_mode_o} !== {4'd5, 4'd6, 2'd1, 4'd14, 2'd0})
      $display("FAIL b2b_second: got v=%b a=%h op=%h sr=%0d sm=%0d dr=%0d dm=%0d want 1/0402/5/6/1/14/0",
               bus.exe_valid_o, bus.exe_addr_o, bus.exe_opcode_o, bus.exe_src_reg_o, bus.exe_src_mode_o, bus.exe_dst_reg_o, bus.exe_dst_mode_o);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.exe_valid_o !== 1'b0) $display("FAIL b2b_done: got %b want 0", bus.exe_valid_o); else n_pass++;
  endtask

  task automatic test_exe_jmp();
    bus.exe_ready_i = 1'b1;
    send_word(16'h0500, 16'hEF80);
    bus.fe_valid_i      = 1'b1;
    bus.fe_data_i       = 16'h4000;
    bus.exe_jmp_valid_i = 1'b1;
    bus.exe_jmp_addr_i  = 16'h0800;
    #1;
    n_checks++; if (bus.fe_ready_o !== 1'b0) $display("FAIL xjmp_ready: got %b want 0", bus.fe_ready_o); else n_pass++;
    @(negedge clk);
    bus.fe_valid_i      = 1'b0;
    bus.exe_jmp_valid_i = 1'b0;
    n_checks++; if (bus.fe_valid_o !== 1'b1 || bus.fe_addr_o !== 16'h0800) $display("FAIL xjmp_wins: got v=%b a=%h want v=1 a=0800", bus.fe_valid_o, bus.fe_addr_o); else n_pass++;
    n_checks++; if (dbg_state !== ST_INST) $display("FAIL xjmp_state: got %0d want %0d", dbg_state, ST_INST); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.fe_valid_o !== 1'b0) $display("FAIL xjmp_single: got %b want 0", bus.fe_valid_o); else n_pass++;
    // The partial jump was discarded: the next word is a fresh opcode.
    send_word(16'h0800, 16'h1234);
    n_checks++; if (bus.exe_valid_o !== 1'b1 || bus.exe_addr_o !== 16'h0800 || bus.exe_opcode_o !== 4'h1)
      $display("FAIL xjmp_fresh: got v=%b a=%h op=%h want 1/0800/1", bus.exe_valid_o, bus.exe_addr_o, bus.exe_opcode_o);
    else n_pass++;
    // Redirect while an instruction waits on EXECUTE, on two consecutive cycles.
    bus.exe_ready_i = 1'b0;
    @(negedge clk);
    bus.exe_jmp_valid_i = 1'b1;
    bus.exe_jmp_addr_i  = 16'h0900;
    @(negedge clk);
    bus.exe_jmp_addr_i = 16'h0A00;
    n_checks++; if (bus.exe_valid_o !== 1'b0 || bus.fe_valid_o !== 1'b1 || bus.fe_addr_o !== 16'h0900)
      $display("FAIL xjmp_out: got ev=%b fv=%b a=%h want 0/1/0900", bus.exe_valid_o, bus.fe_valid_o, bus.fe_addr_o);
    else n_pass++;
    @(negedge clk);
    bus.exe_jmp_valid_i = 1'b0;
    n_checks++; if (bus.fe_valid_o !== 1'b1 || bus.fe_addr_o !== 16'h0A00) $display("FAIL xjmp_consec: got v=%b a=%h want 1/0A00", bus.fe_valid_o, bus.fe_addr_o); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.exe_ready_i = 1'b0;
    send_word(16'h0600, 16'h2FBE);
    send_word(16'h0601, 16'h1111);
    n_checks++; if (dbg_state !== ST_DST || bus.exe_src_imm_o !== 16'h1111) $display("FAIL rmid_pre: got st=%0d simm=%h want st=%0d simm=1111", dbg_state, bus.exe_src_imm_o, ST_DST); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== ST_START || bus.exe_valid_o !== 1'b0 || bus.fe_addr_o !== 16'h0100 || bus.exe_opcode_o !== 4'h0 ||
        bus.exe_src_imm_o !== 16'h0 || bus.exe_addr_o !== 16'h0 || bus.fe_ready_o !== 1'b0 || bus.fe_valid_o !== 1'b0)
      $display("FAIL rmid_async: got st=%0d ev=%b fa=%h op=%h simm=%h ea=%h rdy=%b fv=%b want START/0/0100/0/0000/0000/0/0",
               dbg_state, bus.exe_valid_o, bus.fe_addr_o, bus.exe_opcode_o, bus.exe_src_imm_o, bus.exe_addr_o, bus.fe_ready_o, bus.fe_valid_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.fe_valid_o !== 1'b1 || bus.fe_addr_o !== 16'h0100 || bus.fe_ready_o !== 1'b0)
      $display("FAIL rmid_restart: got v=%b a=%h rdy=%b want 1/0100/0", bus.fe_valid_o, bus.fe_addr_o, bus.fe_ready_o);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_simple();
    test_src_imm_stall();
    test_local_jump();
    test_back_to_back();
    test_exe_jmp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of FETCH, upstream of EXECUTE.
- Consumes the 16-bit instruction word stream from FETCH and assembles each instruction with up to two inline immediate words.
- Hands complete instructions to EXECUTE over a valid/ready handshake.
- Is the sole source of new-PC redirects to FETCH: the reset start, immediate absolute jumps resolved locally, and redirects forwarded from EXECUTE.

Parameters:
- RESET_PC, 16'h0000, first PC sent to FETCH after reset.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- fe_valid_i  in  1  FETCH word valid
- fe_ready_o  out  1  word accepted when fe_valid_i && fe_ready_o
- fe_addr_i  in  16  address of the word
- fe_data_i  in  16  instruction/immediate word
- fe_valid_o  out  1  new-PC pulse to FETCH
- fe_addr_o  out  16  new PC
- exe_valid_o  out  1  decoded instruction valid
- exe_ready_i  in  1  EXECUTE accepts
- exe_addr_o  out  16  address of the opcode word
- exe_opcode_o  out  4  instr[15:12]
- exe_src_reg_o  out  4  instr[11:8]
- exe_src_mode_o  out  2  instr[7:6]
- exe_dst_reg_o  out  4  instr[5:2]
- exe_dst_mode_o  out  2  instr[1:0]
- exe_src_imm_o  out  16  source immediate (0 if none)
- exe_dst_imm_o  out  16  destination immediate (0 if none)
- exe_jmp_valid_i  in  1  EXECUTE redirect request
- exe_jmp_addr_i  in  16  redirect target

Behaviour:
- All outputs are registered, except fe_ready_o.
- Reset values: fe_valid_o=0, fe_addr_o=RESET_PC, exe_valid_o=0, all exe_* fields=0, state=ST_START.
- Immediate detection:
  - Source immediate follows when src_reg==15 && src_mode==2'b10.
  - Destination immediate follows when the same condition holds for the dst fields.
  - Order in the stream: opcode word, then src imm, then dst imm.
- Local jump: opcode 4'hE with a source immediate is consumed in decode and never forwarded. All other instructions, including register-indirect jumps, go to EXECUTE.
- State machine:
  - ST_START: fe_valid_o=1 for exactly one cycle with fe_addr_o=RESET_PC; fe_ready_o=0; next state ST_INST.
  - ST_INST: fe_ready_o=1. On accepting a word, latch the fields and exe_addr. Next state is ST_SRC if src imm, else ST_DST if dst imm, else ST_OUT.
  - ST_SRC: fe_ready_o=1. Latch src imm.
    - If the instruction is a local jump: pulse fe_valid_o with fe_addr_o=imm, go to ST_INST. A dst imm of a local jump is not fetched.
    - Otherwise go to ST_DST if dst imm, else ST_OUT.
  - ST_DST: fe_ready_o=1. Latch dst imm, go to ST_OUT.
  - ST_OUT: exe_valid_o=1 and all exe_* stable until exe_ready_i. fe_ready_o=exe_ready_i, allowing back-to-back acceptance of the next opcode word into ST_INST field capture.
- Latency: opcode word accepted at edge N gives exe_valid_o=1 after edge N, for instructions without immediates. Each immediate adds one accepted word.
- Local-jump redirect: in the cycle fe_valid_o=1, fe_ready_o=0, so no stale word is taken. FETCH supplies only the new stream afterwards.
- exe_jmp_valid_i has highest priority over every state:
  - Next cycle fe_valid_o=1, fe_addr_o=exe_jmp_addr_i.
  - exe_valid_o cleared; any partial instruction discarded; state goes to ST_INST.
  - fe_ready_o=0 in the cycle exe_jmp_valid_i is high.
- Simultaneous local jump and exe_jmp_valid_i: the EXECUTE target wins; the local target is dropped.
- fe_valid_o is never high two consecutive cycles unless EXECUTE redirects on consecutive cycles.
- Reset mid-instruction or mid-handshake: immediate return to reset values. ST_START repeats after deassertion.
- Address/data arithmetic: none. Immediates are passed through unmodified, 16-bit.

Decomposition:
- decode_pkg holds:
  - opcode constants, including C_OP_JMP=4'hE;
  - mode constants, including C_MODE_POSTINC=2'b10;
  - C_PC_REG=4'd15;
  - the state enum (ST_START, ST_INST, ST_SRC, ST_DST, ST_OUT);
  - a pure function returning {has_src_imm, has_dst_imm} from an opcode word.
- No sub-module: a single FSM plus an output register bank.

Test Plan:
- Reset release, RESET_PC=16'h0100 -> one-cycle fe_valid_o with fe_addr_o=16'h0100, fe_ready_o=0 that cycle.
- Word 16'h1234 @0100, exe_ready_i=1 -> exe_valid_o next cycle: opcode 1, src r2 mode 0, dst r13 mode 0, imms 0, exe_addr_o=0100.
- Word 16'h2F80 @0200 then 16'hBEEF -> single exe transfer, src_imm=BEEF, addr 0200. With exe_ready_i=0 for 3 cycles, outputs stable and fe_ready_o=0.
- Local jump 16'hEF80, imm 16'h4000 -> fe_valid_o pulse, fe_addr_o=4000; nothing sent to EXECUTE; fe_ready_o=0 in the pulse cycle.
- exe_jmp_valid_i=1, addr 16'h0800, in the same cycle the local-jump imm is accepted -> fe_addr_o=0800, not the local target; partial state discarded.
- rst_i asserted while in ST_DST with exe_valid_o pending -> all outputs return to reset values asynchronously; ST_START pulse repeats after release.
